// File: rtl/dna_score_max.sv
// Running-maximum tracker for the DNA PE array score stream: reports the
// largest local-alignment score and its (row, col) cell as the traceback start.
module dna_score_max #(
  parameter int SCORE_W = 32,
  parameter int IDX_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W-1:0]   n_rows,
  input  logic [IDX_W-1:0]   n_cols,
  input  logic               en_i,
  input  logic [SCORE_W-1:0] score_i,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] max_score,
  output logic [IDX_W-1:0]   max_row,
  output logic [IDX_W-1:0]   max_col,
  output logic [IDX_W-1:0]   cur_row,
  output logic [IDX_W-1:0]   cur_col
);

  // state | meaning
  // IDLE  | waiting for start, results held
  // RUN   | absorbing enabled samples in row-major order
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic               busy_q, done_q;
  logic [SCORE_W-1:0] max_score_q;
  logic [IDX_W-1:0]   max_row_q, max_col_q;
  logic [IDX_W-1:0]   cur_row_q, cur_col_q;
  logic [IDX_W-1:0]   row_last_q, col_last_q;

  logic [IDX_W-1:0]   row_last_d, col_last_d;
  logic               at_last_col, at_last_row, new_max;

  // Dimensions are stored as last index; a zero dimension degenerates to 1.
  assign row_last_d  = (n_rows == '0) ? '0 : n_rows - IDX_W'(1);
  assign col_last_d  = (n_cols == '0) ? '0 : n_cols - IDX_W'(1);
  assign at_last_col = (cur_col_q == col_last_q);
  assign at_last_row = (cur_row_q == row_last_q);
  assign new_max     = (score_i > max_score_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      max_score_q <= '0;
      max_row_q   <= '0;
      max_col_q   <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      row_last_q  <= '0;
      col_last_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            row_last_q  <= row_last_d;
            col_last_q  <= col_last_d;
            max_score_q <= '0;
            max_row_q   <= '0;
            max_col_q   <= '0;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (en_i) begin
            if (new_max) begin
              max_score_q <= score_i;
              max_row_q   <= cur_row_q;
              max_col_q   <= cur_col_q;
            end
            if (at_last_col) begin
              if (at_last_row) begin
                // Counters hold on the final cell.
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                cur_col_q <= '0;
                cur_row_q <= cur_row_q + IDX_W'(1);
              end
            end else begin
              cur_col_q <= cur_col_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign max_score = max_score_q;
  assign max_row   = max_row_q;
  assign max_col   = max_col_q;
  assign cur_row   = cur_row_q;
  assign cur_col   = cur_col_q;

endmodule
